sobel_pixel_pipe: RTL

//  Upstream pixel source for the VGA timing block. On each pixel strobe it fetches one
//  8-bit grey pixel from frame memory at the VGA-supplied address. It keeps two line

---
 rtl/sobel_pixel_pipe_if.sv | 28 ++
 rtl/sobel_pixel_pipe.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sobel_pixel_pipe_if.sv
// Pixel-strobe / frame-memory / colour bundle between the VGA timing block and sobel_pixel_pipe.
// Strobe protocol: no ready signal exists. PIX_EN is a one-cycle strobe (>= 4 CLK apart).
// MEM_RD is a one-cycle read strobe and MEM_DATA must be valid on the following clock edge.
// COLOUR is a held register that updates once per accepted strobe.
interface sobel_pixel_pipe_if #(
  parameter int ADDR_W = 19
);
  logic              PIX_EN;
  logic [9:0]        ADDRH;
  logic [8:0]        ADDRV;
  logic              REFRESH;
  logic              MEM_RD;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_DATA;
  logic [15:0]       COLOUR;

  // VGA / frame-memory side
  modport master (
    output PIX_EN, ADDRH, ADDRV, REFRESH, MEM_DATA,
    input  MEM_RD, MEM_ADDR, COLOUR
  );

  // Sobel pipeline side
  modport slave (
    input  PIX_EN, ADDRH, ADDRV, REFRESH, MEM_DATA,
    output MEM_RD, MEM_ADDR, COLOUR
  );
endinterface

// File: rtl/sobel_pixel_pipe.sv
// Streaming 3x3 Sobel |Gx|+|Gy| on a raster of grey pixels, RGB565 output, 4-cycle latency.
// Define SOBEL_THRESHOLD_EN to emit a binary edge map (m > THRESH) instead of saturated grey.
module sobel_pixel_pipe #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
`ifdef SOBEL_THRESHOLD_EN
  ,
  parameter int THRESH = 100
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  sobel_pixel_pipe_if.slave bus
);

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [9:0]  V_LIM = 10'(V_RES);

  logic in_win;
  logic take;

  // Stage 1: address / read strobe
  logic              s1_vld_q, s1_vld_d;
  logic [9:0]        x1_q, x1_d;
  logic [8:0]        y1_q, y1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Stage 2: line buffers and window
  logic [7:0]            lb0_mem [H_RES];
  logic [7:0]            lb1_mem [H_RES];
  logic [7:0]            lb0_rd, lb1_rd;
  logic [2:0][2:0][7:0]  win_q, win_d;
  logic                  s2_vld_q, s2_vld_d;
  logic [9:0]            x2_q, x2_d;
  logic [8:0]            y2_q, y2_d;

  // Stage 3: gradients
  logic [9:0]         gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [10:0] gx_q, gx_d, gy_q, gy_d;
  logic               s3_vld_q, s3_vld_d;
  logic               border_q, border_d;

  // Stage 4: colour
  logic [10:0] gx_abs, gy_abs;
  logic [11:0] mag;
  logic [7:0]  grey;
  logic [15:0] colour_f;
  logic [15:0] colour_q, colour_d;

  assign in_win = bus.PIX_EN && ({1'b0, bus.ADDRH} < H_LIM) && ({1'b0, bus.ADDRV} < V_LIM);
  // A coincident REFRESH drops the strobe entirely.
  assign take   = in_win && !bus.REFRESH;

  always_comb begin
    s1_vld_d = take;
    x1_d     = x1_q;
    y1_d     = y1_q;
    addr_d   = addr_q;
    if (take) begin
      x1_d   = bus.ADDRH;
      y1_d   = bus.ADDRV;
      addr_d = ADDR_W'(bus.ADDRV) * ADDR_W'(H_RES) + ADDR_W'(bus.ADDRH);
    end
  end

  assign lb0_rd = lb0_mem[x1_q];
  assign lb1_rd = lb1_mem[x1_q];

  // Line buffers: lb0 holds row y-1, lb1 holds row y-2; read happens before the write.
  always_ff @(posedge CLK) begin
    if (s1_vld_q) begin
      lb0_mem[x1_q] <= bus.MEM_DATA;
      lb1_mem[x1_q] <= lb0_rd;
    end
  end

  always_comb begin
    win_d    = win_q;
    s2_vld_d = 1'b0;
    x2_d     = x2_q;
    y2_d     = y2_q;
    if (bus.REFRESH) begin
      win_d = '0;
    end else if (s1_vld_q) begin
      for (int r = 0; r < 3; r++) begin
        // Column 0 starts a new line: discard whatever the previous line left behind.
        if (x1_q == 10'd0) begin
          win_d[r][0] = 8'd0;
          win_d[r][1] = 8'd0;
        end else begin
          win_d[r][0] = win_q[r][1];
          win_d[r][1] = win_q[r][2];
        end
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = bus.MEM_DATA;
      s2_vld_d    = 1'b1;
      x2_d        = x1_q;
      y2_d        = y1_q;
    end
  end

  assign gx_pos = {2'b00, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b00, win_q[2][2]};
  assign gx_neg = {2'b00, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b00, win_q[2][0]};
  assign gy_pos = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, win_q[2][2]};
  assign gy_neg = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, win_q[0][2]};

  always_comb begin
    s3_vld_d = s2_vld_q && !bus.REFRESH;
    gx_d     = gx_q;
    gy_d     = gy_q;
    border_d = border_q;
    if (s2_vld_q) begin
      gx_d     = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
      gy_d     = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
      // Centre is (x-1, y-1); it is a border pixel when x<2 or y<2.
      border_d = (x2_q < 10'd2) || (y2_q < 9'd2);
    end
  end

  assign gx_abs = gx_q[10] ? 11'(-gx_q) : gx_q;
  assign gy_abs = gy_q[10] ? 11'(-gy_q) : gy_q;
  assign mag    = {1'b0, gx_abs} + {1'b0, gy_abs};
  assign grey   = (mag > 12'd255) ? 8'hFF : mag[7:0];

`ifdef SOBEL_THRESHOLD_EN
  assign colour_f = (mag > 12'(THRESH)) ? 16'hFFFF : 16'h0000;
`else
  assign colour_f = {grey[7:3], grey[7:2], grey[7:3]};
`endif

  always_comb begin
    colour_d = colour_q;
    if (s3_vld_q) begin
      colour_d = border_q ? 16'h0000 : colour_f;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_vld_q <= 1'b0;
      x1_q     <= '0;
      y1_q     <= '0;
      addr_q   <= '0;
      win_q    <= '0;
      s2_vld_q <= 1'b0;
      x2_q     <= '0;
      y2_q     <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
      s3_vld_q <= 1'b0;
      border_q <= 1'b0;
      colour_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      addr_q   <= addr_d;
      win_q    <= win_d;
      s2_vld_q <= s2_vld_d;
      x2_q     <= x2_d;
      y2_q     <= y2_d;
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      s3_vld_q <= s3_vld_d;
      border_q <= border_d;
      colour_q <= colour_d;
    end
  end

  assign bus.MEM_RD   = s1_vld_q;
  assign bus.MEM_ADDR = addr_q;
  assign bus.COLOUR   = colour_q;

endmodule
